// File: rtl/led_color_driver_if.sv
// rtl/led_color_driver_if.sv - tick/pattern inputs and LED bank outputs of the colour driver
interface led_color_driver_if #(
    parameter int NB_LEDS = 4
);
    logic               i_valid;
    logic [NB_LEDS-1:0] i_data;
    logic               i_enable;
    logic [1:0]         i_bright;
    logic [NB_LEDS-1:0] o_led;
    logic [NB_LEDS-1:0] o_ledR;
    logic [NB_LEDS-1:0] o_ledG;

    modport master (
        output i_valid, i_data, i_enable, i_bright,
        input  o_led, o_ledR, o_ledG
    );

    modport slave (
        input  i_valid, i_data, i_enable, i_bright,
        output o_led, o_ledR, o_ledG
    );
endinterface

// File: rtl/led_color_driver.sv
// rtl/led_color_driver.sv - pattern latch, colour rotation FSM and PWM dimming for the LED banks
module led_color_driver #(
    parameter int NB_LEDS         = 4,
    parameter int NB_PWM          = 8,
    parameter int TICKS_PER_COLOR = 8
) (
    input  logic                      clk,
    input  logic                      i_rst,
    led_color_driver_if.slave         bus
);
    localparam int TW = (TICKS_PER_COLOR > 1) ? $clog2(TICKS_PER_COLOR) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICKS_PER_COLOR - 1);
    localparam logic [NB_PWM:0]   PERIOD    = (NB_PWM + 1)'(1) << NB_PWM;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } color_e;

    logic [NB_LEDS-1:0] pat_q, pat_d;
    logic [TW-1:0]      tick_q, tick_d;
    color_e             color_q, color_d;
    logic [NB_PWM-1:0]  pwm_q, pwm_d;
    logic [1:0]         thr_q, thr_d;
    logic [NB_LEDS-1:0] led_q, led_r_q, led_g_q;
    logic [NB_PWM:0]    thr_val;
    logic               accept, wrap, pwm_on, red_en, green_en;

    assign accept = bus.i_valid & bus.i_enable;
    assign wrap   = accept && (tick_q == TICK_LAST);

    always_comb begin
        pat_d  = accept ? bus.i_data : pat_q;
        tick_d = tick_q;
        if (accept) tick_d = wrap ? '0 : tick_q + TW'(1);
        pwm_d  = pwm_q + NB_PWM'(1);
        // threshold only changes on the last cycle of a period so each period has one duty
        thr_d  = (&pwm_q) ? bus.i_bright : thr_q;
    end

    always_comb begin
        case (thr_q)
            2'b00:   thr_val = PERIOD >> 3;
            2'b01:   thr_val = PERIOD >> 2;
            2'b10:   thr_val = PERIOD >> 1;
            default: thr_val = PERIOD;
        endcase
        pwm_on = ({1'b0, pwm_q} < thr_val);
    end

    // Colour FSM: state register
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) color_q <= RED;
        else        color_q <= color_d;
    end

    // Colour FSM: next state, stray encodings fall back to RED
    always_comb begin
        color_d = color_q;
        case (color_q)
            RED:     if (wrap) color_d = GREEN;
            GREEN:   if (wrap) color_d = YELLOW;
            YELLOW:  if (wrap) color_d = RED;
            default: color_d = RED;
        endcase
    end

    // Colour FSM: channel enables
    always_comb begin
        red_en   = 1'b0;
        green_en = 1'b0;
        case (color_q)
            RED:     red_en = 1'b1;
            GREEN:   green_en = 1'b1;
            YELLOW:  begin red_en = 1'b1; green_en = 1'b1; end
            default: begin red_en = 1'b0; green_en = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            pat_q   <= '0;
            tick_q  <= '0;
            pwm_q   <= '0;
            thr_q   <= 2'b00;
            led_q   <= '0;
            led_r_q <= '0;
            led_g_q <= '0;
        end else begin
            pat_q   <= pat_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            thr_q   <= thr_d;
            led_q   <= pat_q;
            led_r_q <= pat_q & {NB_LEDS{red_en & pwm_on}};
            led_g_q <= pat_q & {NB_LEDS{green_en & pwm_on}};
        end
    end

    assign bus.o_led  = led_q;
    assign bus.o_ledR = led_r_q;
    assign bus.o_ledG = led_g_q;
endmodule

// File: tb/tb_led_color_driver.sv
// tb/tb_led_color_driver.sv - randomized and directed checks of led_color_driver against a counting model
module tb_led_color_driver;
    localparam int NL  = 4;
    localparam int NP  = 8;
    localparam int TPC = 8;
    localparam int PER = 1 << NP;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_color_driver_if #(.NB_LEDS(NL)) bus ();

    led_color_driver #(
        .NB_LEDS(NL), .NB_PWM(NP), .TICKS_PER_COLOR(TPC)
    ) dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: colour and PWM phase derived from counts of accepted ticks and cycles since reset
    logic [NL-1:0] m_pat;
    int            m_acc;
    int            m_cyc;
    int            m_thr;
    logic [NL-1:0] e_led, e_r, e_g;

    task automatic model_reset();
        m_pat = '0; m_acc = 0; m_cyc = 0; m_thr = 0;
        e_led = '0; e_r = '0; e_g = '0;
    endtask

    task automatic check(input string tag);
        n_vec++;
        assert (bus.o_led === e_led) else begin
            n_err++;
            $error("FAIL %s o_led observed=%h expected=%h cyc=%0d", tag, bus.o_led, e_led, m_cyc);
        end
        n_vec++;
        assert (bus.o_ledR === e_r) else begin
            n_err++;
            $error("FAIL %s o_ledR observed=%h expected=%h cyc=%0d", tag, bus.o_ledR, e_r, m_cyc);
        end
        n_vec++;
        assert (bus.o_ledG === e_g) else begin
            n_err++;
            $error("FAIL %s o_ledG observed=%h expected=%h cyc=%0d", tag, bus.o_ledG, e_g, m_cyc);
        end
    endtask

    task automatic cycle(input string tag);
        int col, pos, duty;
        bit on;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            col  = (m_acc / TPC) % 3;
            pos  = m_cyc % PER;
            duty = (m_thr == 3) ? PER : ((PER / 8) << m_thr);
            on   = (pos < duty);
            e_led = m_pat;
            e_r   = ((col != 1) && on) ? m_pat : '0;
            e_g   = ((col != 0) && on) ? m_pat : '0;
            if (bus.i_valid && bus.i_enable) begin
                m_pat = bus.i_data;
                m_acc++;
            end
            if (pos == PER - 1) m_thr = int'(bus.i_bright);
            m_cyc++;
        end
        @(negedge clk);
        check(tag);
    endtask

    task automatic accepted_tick(input logic [NL-1:0] d, input string tag);
        bus.i_valid = 1'b1; bus.i_enable = 1'b1; bus.i_data = d;
        cycle(tag);
        bus.i_valid = 1'b0;
    endtask

    initial begin
        int on_cnt, led_cnt, guard;
        model_reset();
        bus.i_valid = 1'b1; bus.i_data = 4'hF; bus.i_enable = 1'b1; bus.i_bright = 2'b11;

        // reset held with an active strobe
        repeat (3) cycle("reset_hold");

        @(negedge clk);
        rst = 1'b1;
        cycle("first_tick");
        bus.i_valid = 1'b0;
        repeat (3) cycle("first_tick_out");

        // colour rotation through all states and back to red
        for (int i = 0; i < 4 * TPC; i++) begin
            accepted_tick(4'b0001, "rotate");
            cycle("rotate_gap");
        end
        repeat (4) cycle("rotate_tail");

        // held strobe: every cycle is a separate tick
        bus.i_valid = 1'b1; bus.i_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.i_data = NL'($urandom);
            cycle("held_valid");
        end
        bus.i_valid = 1'b0;

        // PWM duty at half brightness on red
        guard = 0;
        while (((m_acc / TPC) % 3) != 0 && guard < 64) begin
            accepted_tick(4'hF, "to_red");
            guard++;
        end
        accepted_tick(4'hF, "pat_f");
        bus.i_bright = 2'b10;
        guard = 0;
        do begin cycle("duty_align"); guard++; end while ((m_cyc % PER) != 0 && guard < 2 * PER);
        cycle("duty_align");
        on_cnt = 0; led_cnt = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            cycle("duty");
            if (bus.o_ledR === 4'hF) on_cnt++;
            if (bus.o_led === 4'hF) led_cnt++;
        end
        n_vec++;
        assert (on_cnt === PER) else begin
            n_err++;
            $error("FAIL duty_count observed=%0d expected=%0d", on_cnt, PER);
        end
        n_vec++;
        assert (led_cnt === 2 * PER) else begin
            n_err++;
            $error("FAIL led_steady observed=%0d expected=%0d", led_cnt, 2 * PER);
        end

        // brightness change mid-period
        bus.i_bright = 2'b00;
        guard = 0;
        do begin cycle("bright_wait"); guard++; end while ((m_cyc % PER) != 100 && guard < 3 * PER);
        bus.i_bright = 2'b11;
        repeat (2 * PER) cycle("bright_change");

        // enable freeze with strobes and changing data
        bus.i_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_valid = 1'b1; bus.i_data = NL'($urandom);
            cycle("freeze");
            bus.i_valid = 1'b0;
            cycle("freeze_gap");
        end
        bus.i_enable = 1'b1;
        for (int i = 0; i < 12; i++) accepted_tick(NL'($urandom), "resume");
        repeat (2) cycle("resume_tail");

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.i_valid  = 1'($urandom);
            bus.i_enable = (($urandom % 4) != 0);
            bus.i_data   = NL'($urandom);
            if (($urandom % 64) == 0) bus.i_bright = 2'($urandom);
            cycle("random");
        end

        // async reset between edges in yellow at tick 5
        bus.i_bright = 2'b11;
        guard = 0;
        while (!(((m_acc / TPC) % 3) == 2 && (m_acc % TPC) == 5) && guard < 64) begin
            accepted_tick(NL'($urandom) | 4'b0001, "to_yellow5");
            guard++;
        end
        repeat (2) cycle("yellow5");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_reset");
        @(negedge clk);
        check("async_reset_hold");
        rst = 1'b1;
        for (int i = 0; i < TPC + 2; i++) accepted_tick(4'b0011, "after_reset");
        repeat (3) cycle("after_reset_tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/led_color_driver.md
# led_color_driver

Output stage of the blink-and-move LED path. It consumes the shift register's pattern and the tick counter's `valid` strobe, and drives the board LEDs. The plain LEDs show the pattern unmodulated. The red/green LEDs show the same pattern in a colour that rotates every `TICKS_PER_COLOR` ticks, with PWM brightness dimming. It sits directly downstream of `shift_reg` inside `top_level_leds`.

## Interface
- `NB_LEDS`, 4, pattern width / LEDs per colour bank
- `NB_PWM`, 8, PWM counter width (period = 2^NB_PWM cycles)
- `TICKS_PER_COLOR`, 8, accepted ticks per colour step (≥1)

- `clk`  in  1  system clock
- `i_rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `i_valid`  in  1  single-cycle tick strobe from counter
- `i_data`  in  NB_LEDS  current pattern from shift_reg
- `i_enable`  in  1  1 = accept ticks; 0 = freeze pattern, tick count and colour
- `i_bright`  in  2  brightness select
- `o_led`  out  NB_LEDS  plain LEDs, unmodulated pattern
- `o_ledR`  out  NB_LEDS  red channel, pattern AND red-enable AND PWM
- `o_ledG`  out  NB_LEDS  green channel, pattern AND green-enable AND PWM

## Operation
- Accept: a tick is accepted when `i_valid`=1 and `i_enable`=1. Otherwise `i_valid` is ignored.
- Pattern register `pat_q`: loads `i_data` on each accepted tick. Holds otherwise.
- Tick counter `tick_q`:
  - range 0..TICKS_PER_COLOR-1
  - +1 per accepted tick
  - on an accepted tick while at TICKS_PER_COLOR-1: wraps to 0 and advances the colour FSM
- Colour FSM, 3 states, advances only on tick-counter wrap:
  - RED (R=1, G=0) -> GREEN (R=0, G=1) -> YELLOW (R=1, G=1) -> RED
  - unreachable encoding recovers to RED on the next clock
- PWM:
  - `pwm_q` is a free-running NB_PWM-bit up-counter that wraps at all-ones. It runs regardless of `i_enable`.
  - threshold `thr_q` is reloaded from `i_bright` only when `pwm_q` = all-ones, so every PWM period has a single duty
  - 00 -> 2^NB_PWM/8 (32); 01 -> /4 (64); 10 -> /2 (128); 11 -> always on
  - `pwm_on` = (`thr_q` is always-on) OR (`pwm_q` < `thr_q`)
- Outputs, all registered:
  - `o_led` <= `pat_q`
  - `o_ledR` <= `pat_q` & {NB_LEDS{R & `pwm_on`}}
  - `o_ledG` <= `pat_q` & {NB_LEDS{G & `pwm_on`}}
- Width rules: comparisons unsigned. `tick_q` width is clog2(TICKS_PER_COLOR), minimum 1. With TICKS_PER_COLOR=1, every accepted tick advances the colour.

## Timing
- Reset (`i_rst`=0, asynchronous), all registers cleared at once:
  - `pat_q`=0, `tick_q`=0, colour=RED, `pwm_q`=0
  - `thr_q`=1/8 encoding
  - `o_led`=`o_ledR`=`o_ledG`=0
- Reset release: first accepted tick is processed on the first rising edge with `i_rst`=1.
- Latency:
  - accepted tick at edge n -> `pat_q` updates at n
  - new pattern on outputs after edge n+1 (2 edges from strobe sample)
- Simultaneous events:
  - tick-counter wrap and pattern load on the same accepted tick: new colour and new pattern appear on outputs in the same cycle
  - `i_bright` change mid-period: no effect until after the next `pwm_q` all-ones cycle
- `i_enable` falling: pattern, tick count and colour freeze at their current values. Outputs keep showing the frozen pattern with PWM.
- Reset mid-period or mid-colour: immediate clear. No partial colour or PWM state survives.
- `i_valid` held high for several cycles while enabled: each cycle counts as a separate accepted tick.

## Test plan
- Reset: hold `i_rst`=0 with `i_data`=4'hF and `i_valid`=1 -> all outputs 0, colour RED. Release -> first accepted tick, then `o_led`=4'hF two edges later.
- Colour rotation: TICKS_PER_COLOR=8, `i_bright`=11, 8 ticks with `i_data`=4'b0001 -> `o_ledR`=0001, `o_ledG`=0000. 8 more ticks -> R=0000, G=0001. 8 more -> R=G=0001. 8 more -> back to RED.
- PWM duty: `i_bright`=10, steady pattern 4'hF, colour RED, measure over 2 full periods -> `o_ledR`=4'hF for exactly 128 of 256 cycles per period. `o_led`=4'hF in every cycle.
- Brightness change mid-period: switch 00 -> 11 at `pwm_q`=100 -> current period keeps 32-cycle duty. Next period is fully on.
- Enable freeze: `i_enable`=0 with 5 `i_valid` pulses and changing `i_data` -> `pat_q`, colour and tick count unchanged. Re-enable -> counting resumes from the held `tick_q`.
- Async reset mid-run: assert `i_rst`=0 between edges in YELLOW at `tick_q`=5 -> outputs 0 with no clock edge needed. After release: colour RED, `tick_q`=0.
